// File: rtl/cpld_link_responder_pkg.sv
// Shared constants for the CPLD end of the FPGA<->CPLD display/switch link.
package cpld_link_responder_pkg;

  localparam int FRAME_BITS_DEF = 16;

  // Field positions inside a received display frame.
  localparam int SEG_MSB = 15;
  localparam int SEG_LSB = 8;
  localparam int LED_MSB = 7;
  localparam int LED_LSB = 0;

  // One-hot digit enables.
  localparam logic [1:0] DIG0    = 2'b01;
  localparam logic [1:0] DIG1    = 2'b10;
  localparam logic [1:0] DIG_OFF = 2'b00;

endpackage

// File: rtl/cpld_link_responder_if.sv
// Three-wire link pins plus the return data line.
// The master is the FPGA side and the slave is this CPLD.
interface cpld_link_responder_if;
  logic spi_sclk;
  logic spi_ld;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_ld, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_ld, input spi_mosi, output spi_miso);
endinterface

// File: rtl/cpld_link_responder_sync_edge.sv
// N-stage synchroniser for a W-bit bus.
// Bit 0 of the synchronised bus also gets registered rise/fall strobes.
module link_sync_edge #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise,
  output logic         fall
);

  logic [N-1:0][W-1:0] stage_q, stage_d;
  logic                prev_q, prev_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  // Shift the chain and derive edge strobes from the last stage.
  always_comb begin
    stage_d = {stage_q[N-2:0], d};
    prev_d  = stage_q[N-1][0];
    rise_d  = stage_q[N-1][0] & ~prev_q;
    fall_d  = ~stage_q[N-1][0] & prev_q;
  end

  // Register the synchroniser chain and the strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = stage_q[N-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/cpld_link_responder.sv
// CPLD side of the display/switch link.
// Oversamples the link, deserialises display frames into the LED, segment
// and digit outputs, and returns a switch snapshot on spi_miso.
module cpld_link_responder
  import cpld_link_responder_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int TIMEOUT     = 1048576,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  cpld_link_responder_if.slave  link,
  input  logic [7:0]            sw_in,
  output logic [7:0]            led,
  output logic [7:0]            seg_n,
  output logic [1:0]            dig_sel,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic                  link_up
);

  localparam int         WDW         = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [4:0] BITCNT_LAST = 5'(FRAME_BITS - 1);
  localparam logic [4:0] BITCNT_SAT  = 5'd31;

  logic       sclk_rise;
  logic       sclk_level_unused, sclk_fall_unused;
  logic [1:0] ld_mosi_s;
  logic       ld_mosi_rise_unused, ld_mosi_fall_unused;
  logic [7:0] sw_s;
  logic       sw_rise_unused, sw_fall_unused;
  logic       ld_s, mosi_s;

  link_sync_edge #(.N(SYNC_STAGES), .W(1)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (link.spi_sclk),
    .q (sclk_level_unused), .rise (sclk_rise), .fall (sclk_fall_unused)
  );

  link_sync_edge #(.N(SYNC_STAGES), .W(2)) u_sync_ld_mosi (
    .clk (clk), .rst (rst), .d ({link.spi_ld, link.spi_mosi}),
    .q (ld_mosi_s), .rise (ld_mosi_rise_unused), .fall (ld_mosi_fall_unused)
  );

  link_sync_edge #(.N(2), .W(8)) u_sync_sw (
    .clk (clk), .rst (rst), .d (sw_in),
    .q (sw_s), .rise (sw_rise_unused), .fall (sw_fall_unused)
  );

  assign ld_s   = ld_mosi_s[1];
  assign mosi_s = ld_mosi_s[0];

  logic [FRAME_BITS-1:0] rx_q, rx_d, rx_shift;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [4:0]            bitcnt_q, bitcnt_d;
  logic [WDW-1:0]        wdog_q, wdog_d;
  logic [7:0]            led_q, led_d;
  logic [7:0]            seg_n_q, seg_n_d;
  logic [1:0]            dig_sel_q, dig_sel_d;
  logic                  miso_q, miso_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  frame_err_q, frame_err_d;
  logic                  link_up_q, link_up_d;

  assign rx_shift = {mosi_s, rx_q[FRAME_BITS-1:1]};

  // Frame receive/transmit, judgement and watchdog blanking; an acceptance
  // overrides a same-cycle timeout because it is applied last.
  always_comb begin
    rx_d        = rx_q;
    tx_d        = tx_q;
    bitcnt_d    = bitcnt_q;
    miso_d      = miso_q;
    led_d       = led_q;
    seg_n_d     = seg_n_q;
    dig_sel_d   = dig_sel_q;
    link_up_d   = link_up_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    wdog_d      = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WDW'(1);

    if (wdog_q == WD_MAX) begin
      led_d     = 8'h00;
      seg_n_d   = 8'hFF;
      dig_sel_d = DIG_OFF;
      link_up_d = 1'b0;
    end

    if (sclk_rise) begin
      rx_d     = rx_shift;
      miso_d   = tx_q[0];
      tx_d     = tx_q >> 1;
      bitcnt_d = (bitcnt_q == BITCNT_SAT) ? bitcnt_q : bitcnt_q + 5'd1;
      if (ld_s) begin
        bitcnt_d  = 5'd0;
        tx_d      = '0;
        tx_d[7:0] = sw_s;
        if (bitcnt_q == BITCNT_LAST) begin
          led_d      = rx_shift[LED_MSB:LED_LSB];
          seg_n_d    = ~rx_shift[SEG_MSB:SEG_LSB];
          dig_sel_d  = (dig_sel_q == DIG0) ? DIG1 : DIG0;
          link_up_d  = 1'b1;
          frame_ok_d = 1'b1;
          wdog_d     = '0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q        <= '0;
      tx_q        <= '0;
      bitcnt_q    <= BITCNT_SAT;
      wdog_q      <= '0;
      led_q       <= 8'h00;
      seg_n_q     <= 8'hFF;
      dig_sel_q   <= DIG_OFF;
      miso_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      link_up_q   <= 1'b0;
    end else begin
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      bitcnt_q    <= bitcnt_d;
      wdog_q      <= wdog_d;
      led_q       <= led_d;
      seg_n_q     <= seg_n_d;
      dig_sel_q   <= dig_sel_d;
      miso_q      <= miso_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      link_up_q   <= link_up_d;
    end
  end

  assign link.spi_miso = miso_q;
  assign led           = led_q;
  assign seg_n         = seg_n_q;
  assign dig_sel       = dig_sel_q;
  assign frame_ok      = frame_ok_q;
  assign frame_err     = frame_err_q;
  assign link_up       = link_up_q;

endmodule

// File: tb/tb_cpld_link_responder.sv
// Directed bench for cpld_link_responder with a short watchdog.
module tb_cpld_link_responder;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw_in;
  logic [7:0] led, seg_n;
  logic [1:0] dig_sel;
  logic       frame_ok, frame_err, link_up;

  int errors = 0;
  int checks = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic        last_miso;
  logic [15:0] cap_word;

  cpld_link_responder_if lk ();

  cpld_link_responder #(.FRAME_BITS(16), .TIMEOUT(256), .SYNC_STAGES(2)) dut (
    .clk (clk), .rst (rst), .link (lk.slave), .sw_in (sw_in),
    .led (led), .seg_n (seg_n), .dig_sel (dig_sel),
    .frame_ok (frame_ok), .frame_err (frame_err), .link_up (link_up)
  );

  always #5 clk = ~clk;

  // Count pulse cycles so each pulse width is also checked.
  always @(posedge clk) begin
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
    if (frame_ok && frame_err) both_cnt++;
  end

  task automatic send_slot(input logic m, input logic l);
    lk.spi_sclk = 1'b0;
    lk.spi_mosi = m;
    lk.spi_ld   = l;
    repeat (HALF) @(negedge clk);
    lk.spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    last_miso = lk.spi_miso;
  endtask

  task automatic send_frame(input logic [15:0] w);
    for (int k = 0; k < 16; k++) begin
      send_slot(w[k], k == 15);
      cap_word[k] = last_miso;
    end
    lk.spi_sclk = 1'b0;
    lk.spi_ld   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led); end
    checks++; if (seg_n !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg_n); end
    checks++; if (dig_sel !== 2'b00) begin errors++; $display("FAIL reset_dig: got %b want 00", dig_sel); end
    checks++; if (lk.spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", lk.spi_miso); end
    checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b want 0", frame_ok); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link: got %b want 0", link_up); end
  endtask

  task automatic test_single_frame();
    int ok0, err0;
    err0 = err_cnt;
    send_slot(1'b0, 1'b1);
    lk.spi_ld = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (err_cnt - err0 !== 1) begin errors++; $display("FAIL align_err: got %0d want 1", err_cnt - err0); end
    ok0 = ok_cnt; err0 = err_cnt;
    send_frame(16'h3FA5);
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL single_led: got %h want a5", led); end
    checks++; if (seg_n !== 8'hC0) begin errors++; $display("FAIL single_seg: got %h want c0", seg_n); end
    checks++; if (dig_sel !== 2'b01) begin errors++; $display("FAIL single_dig: got %b want 01", dig_sel); end
    checks++; if (ok_cnt - ok0 !== 1) begin errors++; $display("FAIL single_ok: got %0d want 1", ok_cnt - ok0); end
    checks++; if (err_cnt - err0 !== 0) begin errors++; $display("FAIL single_err: got %0d want 0", err_cnt - err0); end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL single_link: got %b want 1", link_up); end
  endtask

  task automatic test_back_to_back();
    int ok0;
    ok0 = ok_cnt;
    send_frame(16'h1234);
    checks++; if (dig_sel !== 2'b10) begin errors++; $display("FAIL b2b_dig1: got %b want 10", dig_sel); end
    checks++; if (led !== 8'h34) begin errors++; $display("FAIL b2b_led1: got %h want 34", led); end
    checks++; if (seg_n !== 8'hED) begin errors++; $display("FAIL b2b_seg1: got %h want ed", seg_n); end
    send_frame(16'h5678);
    checks++; if (dig_sel !== 2'b01) begin errors++; $display("FAIL b2b_dig2: got %b want 01", dig_sel); end
    checks++; if (led !== 8'h78) begin errors++; $display("FAIL b2b_led2: got %h want 78", led); end
    checks++; if (seg_n !== 8'hA9) begin errors++; $display("FAIL b2b_seg2: got %h want a9", seg_n); end
    checks++; if (ok_cnt - ok0 !== 2) begin errors++; $display("FAIL b2b_ok: got %0d want 2", ok_cnt - ok0); end
  endtask

  task automatic test_miso();
    sw_in = 8'h5A;
    repeat (4) @(negedge clk);
    send_frame(16'h00FF);
    sw_in = 8'hFF;
    send_frame(16'h0F0F);
    checks++; if (cap_word !== 16'h005A) begin errors++; $display("FAIL miso_bits: got %h want 005a", cap_word); end
    checks++; if (led !== 8'h0F) begin errors++; $display("FAIL miso_led: got %h want 0f", led); end
  endtask

  task automatic test_short_frame();
    int ok0, err0;
    ok0 = ok_cnt; err0 = err_cnt;
    for (int k = 0; k < 12; k++) send_slot(1'b1, 1'b0);
    send_slot(1'b1, 1'b1);
    lk.spi_sclk = 1'b0;
    lk.spi_ld   = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (err_cnt - err0 !== 1) begin errors++; $display("FAIL short_err: got %0d want 1", err_cnt - err0); end
    checks++; if (ok_cnt - ok0 !== 0) begin errors++; $display("FAIL short_ok: got %0d want 0", ok_cnt - ok0); end
    checks++; if (led !== 8'h0F) begin errors++; $display("FAIL short_led: got %h want 0f", led); end
    checks++; if (seg_n !== 8'hF0) begin errors++; $display("FAIL short_seg: got %h want f0", seg_n); end
    ok0 = ok_cnt;
    send_frame(16'hC33C);
    checks++; if (ok_cnt - ok0 !== 1) begin errors++; $display("FAIL short_next_ok: got %0d want 1", ok_cnt - ok0); end
    checks++; if (led !== 8'h3C) begin errors++; $display("FAIL short_next_led: got %h want 3c", led); end
    checks++; if (seg_n !== 8'h3C) begin errors++; $display("FAIL short_next_seg: got %h want 3c", seg_n); end
  endtask

  task automatic test_timeout();
    repeat (150) @(negedge clk);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL to_early_link: got %b want 1", link_up); end
    checks++; if (led !== 8'h3C) begin errors++; $display("FAIL to_early_led: got %h want 3c", led); end
    repeat (150) @(negedge clk);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL to_link: got %b want 0", link_up); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL to_led: got %h want 00", led); end
    checks++; if (seg_n !== 8'hFF) begin errors++; $display("FAIL to_seg: got %h want ff", seg_n); end
    checks++; if (dig_sel !== 2'b00) begin errors++; $display("FAIL to_dig: got %b want 00", dig_sel); end
    send_frame(16'h7E81);
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL to_rest_link: got %b want 1", link_up); end
    checks++; if (led !== 8'h81) begin errors++; $display("FAIL to_rest_led: got %h want 81", led); end
    checks++; if (seg_n !== 8'h81) begin errors++; $display("FAIL to_rest_seg: got %h want 81", seg_n); end
    checks++; if (dig_sel !== 2'b01) begin errors++; $display("FAIL to_rest_dig: got %b want 01", dig_sel); end
  endtask

  task automatic test_reset_mid_frame();
    int ok0, err0;
    for (int k = 0; k < 7; k++) send_slot(1'b1, 1'b0);
    lk.spi_sclk = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL mid_rst_led: got %h want 00", led); end
    checks++; if (seg_n !== 8'hFF) begin errors++; $display("FAIL mid_rst_seg: got %h want ff", seg_n); end
    checks++; if (dig_sel !== 2'b00) begin errors++; $display("FAIL mid_rst_dig: got %b want 00", dig_sel); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL mid_rst_link: got %b want 0", link_up); end
    checks++; if (lk.spi_miso !== 1'b0) begin errors++; $display("FAIL mid_rst_miso: got %b want 0", lk.spi_miso); end
    ok0 = ok_cnt; err0 = err_cnt;
    for (int k = 7; k < 16; k++) send_slot(1'b1, k == 15);
    lk.spi_sclk = 1'b0;
    lk.spi_ld   = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (err_cnt - err0 !== 1) begin errors++; $display("FAIL mid_trail_err: got %0d want 1", err_cnt - err0); end
    checks++; if (ok_cnt - ok0 !== 0) begin errors++; $display("FAIL mid_trail_ok: got %0d want 0", ok_cnt - ok0); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL mid_trail_led: got %h want 00", led); end
  endtask

  initial begin
    rst         = 1'b1;
    sw_in       = 8'h00;
    lk.spi_sclk = 1'b0;
    lk.spi_ld   = 1'b0;
    lk.spi_mosi = 1'b0;
    last_miso   = 1'b0;
    cap_word    = 16'h0000;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_miso();
    test_short_frame();
    test_timeout();
    test_reset_mid_frame();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL ok_err_overlap: got %0d want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
